// File: rtl/riscv_pkg.sv
// Shared core-wide definitions: datapath widths and ALU opcode encodings.
package riscv_pkg;

    localparam int XLEN = 32;
    localparam int RW   = 5;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1100;

endpackage

// File: rtl/fwd_mux.sv
// Operand forwarding select: the MEM result beats the WB result, and x0 never forwards.
module fwd_mux #(
    parameter int XLEN = 32,
    parameter int RW   = 5
) (
    input  logic [RW-1:0]   src,
    input  logic [XLEN-1:0] v,
    input  logic            mem_en,
    input  logic [RW-1:0]   mem_rd,
    input  logic [XLEN-1:0] mem_data,
    input  logic            wb_en,
    input  logic [RW-1:0]   wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic [XLEN-1:0] value
);

    always_comb begin
        value = v;
        if (src != '0) begin
            if (mem_en && (mem_rd == src)) begin
                value = mem_data;
            end else if (wb_en && (wb_rd == src)) begin
                value = wb_data;
            end
        end
    end

endmodule

// File: rtl/alu_issue.sv
// One-deep ID/EX slot. It holds a decoded instruction and drives forwarded operands into the ALU.
module alu_issue
    import riscv_pkg::*;
#(
    parameter int XLEN = riscv_pkg::XLEN,
    parameter int RW   = riscv_pkg::RW
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [RW-1:0]   in_rs1,
    input  logic [RW-1:0]   in_rs2,
    input  logic [XLEN-1:0] in_rs1_data,
    input  logic [XLEN-1:0] in_rs2_data,
    input  logic [XLEN-1:0] in_imm,
    input  logic            in_use_imm,
    input  logic [3:0]      in_alu_control,
    input  logic [RW-1:0]   in_rd,
    input  logic            in_reg_write,
    input  logic            flush,
    input  logic            mem_fwd_en,
    input  logic [RW-1:0]   mem_fwd_rd,
    input  logic [XLEN-1:0] mem_fwd_data,
    input  logic            wb_fwd_en,
    input  logic [RW-1:0]   wb_fwd_rd,
    input  logic [XLEN-1:0] wb_fwd_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] alu_a,
    output logic [XLEN-1:0] alu_b,
    output logic [3:0]      alu_control,
    output logic [RW-1:0]   out_rd,
    output logic            out_reg_write,
    output logic [XLEN-1:0] out_store_data
);

    logic            valid_q;
    logic [RW-1:0]   rs1_q;
    logic [RW-1:0]   rs2_q;
    logic [XLEN-1:0] op1_q;
    logic [XLEN-1:0] op2_q;
    logic [XLEN-1:0] imm_q;
    logic            use_imm_q;
    logic [3:0]      ctl_q;
    logic [RW-1:0]   rd_q;
    logic            rw_q;

    logic            accept;
    logic            stall;
    logic [XLEN-1:0] fwd1;
    logic [XLEN-1:0] fwd2;

    assign in_ready = !valid_q || out_ready;
    assign accept   = in_valid && in_ready && !flush;
    assign stall    = valid_q && !out_ready;

    fwd_mux #(.XLEN(XLEN), .RW(RW)) u_fwd_rs1 (
        .src      (rs1_q),
        .v        (op1_q),
        .mem_en   (mem_fwd_en),
        .mem_rd   (mem_fwd_rd),
        .mem_data (mem_fwd_data),
        .wb_en    (wb_fwd_en),
        .wb_rd    (wb_fwd_rd),
        .wb_data  (wb_fwd_data),
        .value    (fwd1)
    );

    fwd_mux #(.XLEN(XLEN), .RW(RW)) u_fwd_rs2 (
        .src      (rs2_q),
        .v        (op2_q),
        .mem_en   (mem_fwd_en),
        .mem_rd   (mem_fwd_rd),
        .mem_data (mem_fwd_data),
        .wb_en    (wb_fwd_en),
        .wb_rd    (wb_fwd_rd),
        .wb_data  (wb_fwd_data),
        .value    (fwd2)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
        end else if (flush) begin
            valid_q <= 1'b0;
        end else if (accept) begin
            valid_q <= 1'b1;
        end else if (out_ready) begin
            valid_q <= 1'b0;
        end
    end

    // While stalled, captured forwards are written back so a producer that retires mid-stall is not lost.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rs1_q     <= '0;
            rs2_q     <= '0;
            op1_q     <= '0;
            op2_q     <= '0;
            imm_q     <= '0;
            use_imm_q <= 1'b0;
            ctl_q     <= ALU_AND;
            rd_q      <= '0;
            rw_q      <= 1'b0;
        end else if (accept) begin
            rs1_q     <= in_rs1;
            rs2_q     <= in_rs2;
            op1_q     <= in_rs1_data;
            op2_q     <= in_rs2_data;
            imm_q     <= in_imm;
            use_imm_q <= in_use_imm;
            ctl_q     <= in_alu_control;
            rd_q      <= in_rd;
            rw_q      <= in_reg_write;
        end else if (stall) begin
            op1_q     <= fwd1;
            op2_q     <= fwd2;
        end
    end

    assign out_valid      = valid_q;
    assign alu_a          = fwd1;
    assign alu_b          = use_imm_q ? imm_q : fwd2;
    assign alu_control    = ctl_q;
    assign out_rd         = rd_q;
    assign out_reg_write  = rw_q;
    assign out_store_data = fwd2;

endmodule

// File: tb/tb_alu_issue.sv
// Bench for alu_issue: directed scenarios plus random traffic, with a scoreboard fed by a reference model.
module tb_alu_issue;
    import riscv_pkg::*;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [4:0]  in_rs1, in_rs2;
    logic [31:0] in_rs1_data, in_rs2_data, in_imm;
    logic        in_use_imm;
    logic [3:0]  in_alu_control;
    logic [4:0]  in_rd;
    logic        in_reg_write;
    logic        flush;
    logic        mem_fwd_en;
    logic [4:0]  mem_fwd_rd;
    logic [31:0] mem_fwd_data;
    logic        wb_fwd_en;
    logic [4:0]  wb_fwd_rd;
    logic [31:0] wb_fwd_data;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] alu_a, alu_b;
    logic [3:0]  alu_control;
    logic [4:0]  out_rd;
    logic        out_reg_write;
    logic [31:0] out_store_data;

    alu_issue dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data),
        .in_imm(in_imm), .in_use_imm(in_use_imm),
        .in_alu_control(in_alu_control), .in_rd(in_rd), .in_reg_write(in_reg_write),
        .flush(flush),
        .mem_fwd_en(mem_fwd_en), .mem_fwd_rd(mem_fwd_rd), .mem_fwd_data(mem_fwd_data),
        .wb_fwd_en(wb_fwd_en), .wb_fwd_rd(wb_fwd_rd), .wb_fwd_data(wb_fwd_data),
        .out_valid(out_valid), .out_ready(out_ready),
        .alu_a(alu_a), .alu_b(alu_b), .alu_control(alu_control),
        .out_rd(out_rd), .out_reg_write(out_reg_write), .out_store_data(out_store_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected a finished run");
        $fatal(1, "watchdog");
    end

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  ctl;
        logic [4:0]  rd;
        logic        rw;
        logic [31:0] sd;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    logic exp_rdy  = 1'b1;

    // Reference model of the slot: what instruction is held and its last known operand values.
    logic        m_valid;
    logic [4:0]  m_rs1, m_rs2, m_rd;
    logic [31:0] m_op1, m_op2, m_imm;
    logic        m_use_imm, m_rw;
    logic [3:0]  m_ctl;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] mfwd(input logic [4:0] src, input logic [31:0] v);
        if (src == 5'd0) return v;
        if (mem_fwd_en && mem_fwd_rd == src) return mem_fwd_data;
        if (wb_fwd_en && wb_fwd_rd == src) return wb_fwd_data;
        return v;
    endfunction

    task automatic model_reset();
        m_valid = 0; m_rs1 = 0; m_rs2 = 0; m_rd = 0; m_op1 = 0; m_op2 = 0;
        m_imm = 0; m_use_imm = 0; m_rw = 0; m_ctl = 0;
    endtask

    task automatic model_observe();
        exp_t e;
        exp_rdy = !m_valid || out_ready;
        if (m_valid) begin
            e.a   = mfwd(m_rs1, m_op1);
            e.sd  = mfwd(m_rs2, m_op2);
            e.b   = m_use_imm ? m_imm : e.sd;
            e.ctl = m_ctl;
            e.rd  = m_rd;
            e.rw  = m_rw;
            sb.push_back(e);
        end
    endtask

    task automatic model_edge();
        logic        acc;
        logic [31:0] n1, n2;
        acc = in_valid && (!m_valid || out_ready) && !flush;
        if (acc) begin
            m_rs1 = in_rs1; m_rs2 = in_rs2; m_op1 = in_rs1_data; m_op2 = in_rs2_data;
            m_imm = in_imm; m_use_imm = in_use_imm; m_ctl = in_alu_control;
            m_rd = in_rd; m_rw = in_reg_write;
        end else if (m_valid && !out_ready) begin
            n1 = mfwd(m_rs1, m_op1);
            n2 = mfwd(m_rs2, m_op2);
            m_op1 = n1;
            m_op2 = n2;
        end
        if (flush) m_valid = 0;
        else if (acc) m_valid = 1;
        else if (out_ready) m_valid = 0;
    endtask

    // One clock: expectations are issued at the falling edge, state advances at the rising edge.
    task automatic step();
        @(negedge clk);
        model_observe();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle();
        in_valid = 0; flush = 0; mem_fwd_en = 0; wb_fwd_en = 0; out_ready = 1;
        in_use_imm = 0;
    endtask

    task automatic async_rst();
        #1 rst = 1;
        #1 chk("async_rst_out_valid", {31'd0, out_valid}, 32'd0);
        model_reset();
        #1 rst = 0;
    endtask

    // Monitor: every cycle the DUT presents an instruction, compare it with the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            chk("in_ready", {31'd0, in_ready}, {31'd0, exp_rdy});
            if (out_valid === 1'b1) begin
                if (sb.size() == 0) begin
                    chk("unexpected_out_valid", {31'd0, out_valid}, 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("alu_a", alu_a, e.a);
                    chk("alu_b", alu_b, e.b);
                    chk("alu_control", {28'd0, alu_control}, {28'd0, e.ctl});
                    chk("out_rd", {27'd0, out_rd}, {27'd0, e.rd});
                    chk("out_reg_write", {31'd0, out_reg_write}, {31'd0, e.rw});
                    chk("out_store_data", out_store_data, e.sd);
                end
            end else if (sb.size() != 0) begin
                chk("missing_out_valid", {31'd0, out_valid}, 32'd1);
                sb.delete();
            end
        end
    end

    logic [3:0] ops [6];

    initial begin
        ops = '{ALU_AND, ALU_OR, ALU_ADD, ALU_SUB, ALU_SLT, ALU_NOR};
        rst = 1;
        in_rs1 = 0; in_rs2 = 0; in_rs1_data = 0; in_rs2_data = 0; in_imm = 0;
        in_alu_control = 0; in_rd = 0; in_reg_write = 0;
        mem_fwd_rd = 0; mem_fwd_data = 0; wb_fwd_rd = 0; wb_fwd_data = 0;
        idle();
        model_reset();
        repeat (3) @(posedge clk);
        #1 rst = 0;
        #1;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_alu_a", alu_a, 32'd0);
        chk("rst_alu_b", alu_b, 32'd0);
        chk("rst_alu_control", {28'd0, alu_control}, 32'd0);
        chk("rst_out_rd", {27'd0, out_rd}, 32'd0);
        chk("rst_out_reg_write", {31'd0, out_reg_write}, 32'd0);
        chk("rst_out_store_data", out_store_data, 32'd0);
        chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

        // Basic issue
        in_valid = 1; in_rs1 = 1; in_rs2 = 2; in_rs1_data = 5; in_rs2_data = 7;
        in_alu_control = ALU_ADD; in_rd = 3; in_reg_write = 1;
        step();
        idle();
        #1;
        chk("basic_valid", {31'd0, out_valid}, 32'd1);
        chk("basic_a", alu_a, 32'd5);
        chk("basic_b", alu_b, 32'd7);
        chk("basic_ctl", {28'd0, alu_control}, 32'h2);
        chk("basic_rd", {27'd0, out_rd}, 32'd3);
        step();

        // Forwarding priority on a held rs1
        in_valid = 1; in_rs1 = 4; in_rs1_data = 32'h11; in_rs2 = 0; in_rs2_data = 0;
        in_alu_control = ALU_OR;
        step();
        idle();
        mem_fwd_en = 1; mem_fwd_rd = 4; mem_fwd_data = 32'hAA;
        wb_fwd_en = 1; wb_fwd_rd = 4; wb_fwd_data = 32'hBB;
        #1 chk("fwd_mem_prio", alu_a, 32'hAA);
        mem_fwd_en = 0;
        #1 chk("fwd_wb", alu_a, 32'hBB);
        mem_fwd_en = 1; mem_fwd_rd = 0; wb_fwd_rd = 0;
        #1 chk("fwd_none", alu_a, 32'h11);
        step();
        idle();

        // x0 never forwards
        in_valid = 1; in_rs1 = 0; in_rs1_data = 32'h55;
        step();
        idle();
        mem_fwd_en = 1; mem_fwd_rd = 0; mem_fwd_data = 32'h99;
        wb_fwd_en = 1; wb_fwd_rd = 0; wb_fwd_data = 32'h77;
        #1 chk("fwd_x0", alu_a, 32'h55);
        step();
        idle();

        // Stall refresh: a WB producer seen for one stalled cycle must stick
        in_valid = 1; in_rs1 = 1; in_rs1_data = 1; in_rs2 = 6; in_rs2_data = 32'h22;
        in_alu_control = ALU_SUB; in_use_imm = 0;
        step();
        idle();
        out_ready = 0;
        wb_fwd_en = 1; wb_fwd_rd = 6; wb_fwd_data = 32'h1234;
        step();
        wb_fwd_en = 0;
        #1 chk("stall_b_0", alu_b, 32'h1234);
        step();
        chk("stall_b_1", alu_b, 32'h1234);
        chk("stall_valid", {31'd0, out_valid}, 32'd1);
        out_ready = 1;
        step();
        chk("stall_drained", {31'd0, out_valid}, 32'd0);

        // Immediate path with rs2 still forwarded to store data
        in_valid = 1; in_rs2 = 9; in_rs2_data = 32'h33; in_use_imm = 1; in_imm = 32'hFFFFFFFC;
        step();
        idle();
        mem_fwd_en = 1; mem_fwd_rd = 9; mem_fwd_data = 32'hCAFE;
        #1;
        chk("imm_b", alu_b, 32'hFFFFFFFC);
        chk("imm_store", out_store_data, 32'hCAFE);
        step();
        idle();

        // Flush wins over accept, and kills a held instruction
        in_valid = 1; flush = 1;
        step();
        chk("flush_accept", {31'd0, out_valid}, 32'd0);
        flush = 0;
        step();
        in_valid = 0; out_ready = 0; flush = 1;
        step();
        chk("flush_held", {31'd0, out_valid}, 32'd0);
        idle();

        // Asynchronous reset in the middle of a stall
        in_valid = 1; in_rs1 = 2; in_rs1_data = 32'h77;
        step();
        in_valid = 0; out_ready = 0;
        step();
        async_rst();
        chk("async_rst_alu_a", alu_a, 32'd0);
        idle();
        step();

        // Random traffic
        for (int i = 0; i < 3000; i++) begin
            in_valid       = ($urandom_range(0, 9) < 7);
            in_rs1         = 5'($urandom_range(0, 7));
            in_rs2         = 5'($urandom_range(0, 7));
            in_rs1_data    = $urandom;
            in_rs2_data    = $urandom;
            in_imm         = $urandom;
            in_use_imm     = ($urandom_range(0, 3) == 0);
            in_alu_control = ops[$urandom_range(0, 5)];
            in_rd          = 5'($urandom_range(0, 31));
            in_reg_write   = 1'($urandom_range(0, 1));
            flush          = ($urandom_range(0, 19) == 0);
            mem_fwd_en     = 1'($urandom_range(0, 1));
            mem_fwd_rd     = 5'($urandom_range(0, 7));
            mem_fwd_data   = $urandom;
            wb_fwd_en      = 1'($urandom_range(0, 1));
            wb_fwd_rd      = 5'($urandom_range(0, 7));
            wb_fwd_data    = $urandom;
            out_ready      = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 499) == 0) async_rst();
            step();
        end

        idle();
        repeat (3) step();
        @(negedge clk);
        #2;
        chk("scoreboard_empty", sb.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
